// File: rtl/display_digit_scanner.sv
// Signed value -> serial double-dabble BCD -> sign/blank/error format -> scanned digit codes.
// Optional SCANNER_LZB_EN: blank leading zeros and float the minus sign next to the MSD.
module display_digit_scanner #(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     value,
  input  logic                  error_in,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [3:0] C_DASH  = 4'hA;
  localparam logic [3:0] C_ERR   = 4'hE;
  localparam logic [3:0] C_BLANK = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FMT
  } state_t;

  state_t state, nxt;

  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] bin, bin_n;
  logic [BW-1:0]     bcd, adj, bcd_n;
  logic              neg, err, ovf, ovf_n;
  logic              fmt_q, fmt_bad;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     msd, idx, idx_n;
  logic [PW-1:0]     presc;
  logic              wrap;
  logic [3:0]        disp [NUM_DIGITS];
  logic [3:0]        fmt  [NUM_DIGITS];

  // Unsigned DATA_W-bit magnitude is exact even for the most negative input.
  assign mag  = value[DATA_W-1] ? (~value + 1'b1) : value;
  assign busy = (state != S_IDLE);
  assign wrap = (presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (load) nxt = S_CONV;
      S_CONV: if (cnt == CW'(DATA_W - 1)) nxt = S_FMT;
      S_FMT:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_n = {adj[BW-2:0], bin[DATA_W-1]};
    bin_n = {bin[DATA_W-2:0], 1'b0};
    ovf_n = ovf | adj[BW-1];
  end

  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = IW'(i);
    end
  end

  // A minus sign needs a free digit above the MSD in both display modes.
  assign fmt_bad = err | ovf | (neg & (msd == IW'(NUM_DIGITS - 1)));

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      fmt[i] = C_BLANK;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SCANNER_LZB_EN
      if (i <= int'(msd)) begin
        fmt[i] = bcd[4*i +: 4];
      end else if (neg && (i == int'(msd) + 1)) begin
        fmt[i] = C_DASH;
      end
`else
      fmt[i] = bcd[4*i +: 4];
`endif
    end
`ifndef SCANNER_LZB_EN
    if (neg) fmt[NUM_DIGITS-1] = C_DASH;
`endif
    if (fmt_bad) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        fmt[i] = C_BLANK;
      end
      fmt[NUM_DIGITS-1] = C_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin   <= '0;
      bcd   <= '0;
      neg   <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      fmt_q <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp[i] <= C_BLANK;
      end
    end else begin
      fmt_q <= (state == S_FMT);
      done  <= fmt_q;
      if (state == S_IDLE && load) begin
        bin <= mag;
        bcd <= '0;
        neg <= value[DATA_W-1];
        err <= error_in;
        ovf <= 1'b0;
        cnt <= '0;
      end
      if (state == S_CONV) begin
        bin <= bin_n;
        bcd <= bcd_n;
        ovf <= ovf_n;
        cnt <= cnt + 1'b1;
      end
      if (state == S_FMT) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          disp[i] <= fmt[i];
        end
      end
    end
  end

  always_comb begin
    idx_n = idx;
    if (wrap) begin
      idx_n = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      digit_sel  <= NUM_DIGITS'(1);
      digit_code <= C_BLANK;
    end else begin
      presc      <= wrap ? '0 : presc + 1'b1;
      idx        <= idx_n;
      digit_sel  <= NUM_DIGITS'(1) << idx_n;
      digit_code <= disp[idx_n];
    end
  end

endmodule
